// File: rtl/l15_responder_model_if.sv
// Transducer <-> L1.5 request/response signal bundle for l15_responder_model.
interface l15_responder_model_if;
  logic [4:0]  transducer_l15_rqtype;
  logic [2:0]  transducer_l15_size;
  logic [31:0] transducer_l15_address;
  logic [63:0] transducer_l15_data;
  logic        transducer_l15_val;
  logic        l15_transducer_ack;
  logic        l15_transducer_header_ack;
  logic        l15_transducer_val;
  logic [63:0] l15_transducer_data_0;
  logic [63:0] l15_transducer_data_1;
  logic [31:0] l15_transducer_returntype;
  logic        transducer_l15_req_ack;
  logic        err;

  modport master (
    output transducer_l15_rqtype, transducer_l15_size, transducer_l15_address,
           transducer_l15_data, transducer_l15_val, transducer_l15_req_ack,
    input  l15_transducer_ack, l15_transducer_header_ack, l15_transducer_val,
           l15_transducer_data_0, l15_transducer_data_1, l15_transducer_returntype, err
  );

  modport slave (
    input  transducer_l15_rqtype, transducer_l15_size, transducer_l15_address,
           transducer_l15_data, transducer_l15_val, transducer_l15_req_ack,
    output l15_transducer_ack, l15_transducer_header_ack, l15_transducer_val,
           l15_transducer_data_0, l15_transducer_data_1, l15_transducer_returntype, err
  );
endinterface

// File: rtl/l15_responder_model.sv
// Single-outstanding L1.5 responder backed by a 64-bit memory with programmable latency.
// Optional interrupt injection is enabled by defining L15_RESP_INT_EN.
module l15_responder_model #(
  parameter int unsigned MEM_DWORDS = 4096,
  parameter int unsigned LATENCY    = 2
) (
  input  logic clk,
  input  logic nrst,
`ifdef L15_RESP_INT_EN
  input  logic int_req,
`endif
  l15_responder_model_if.slave bus
);
  localparam int unsigned AW = $clog2(MEM_DWORDS);

  localparam logic [4:0] RQ_LOAD  = 5'b00000;
  localparam logic [4:0] RQ_IMISS = 5'b10000;
  localparam logic [4:0] RQ_STORE = 5'b00001;

  localparam logic [3:0] RT_LOAD  = 4'b0000;
  localparam logic [3:0] RT_IFILL = 4'b0001;
  localparam logic [3:0] RT_STACK = 4'b0100;
  localparam logic [3:0] RT_ERR   = 4'b1111;
`ifdef L15_RESP_INT_EN
  localparam logic [3:0] RT_INT   = 4'b0111;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  logic [4:0]  r_rqtype;
  logic [2:0]  r_size;
  logic [31:0] r_addr;
  logic [63:0] r_wdata;
  logic [7:0]  r_cnt;
  logic        r_ack;
  logic        r_val;
  logic [63:0] r_d0;
  logic [63:0] r_d1;
  logic [3:0]  r_rt;
  logic        r_err;
  logic [63:0] r_mem [MEM_DWORDS];

  logic [3:0]    w_bytes;
  logic [2:0]    w_align_mask;
  logic          w_size_ok;
  logic          w_rq_ok;
  logic          w_bad;
  logic [AW-1:0] w_idx;
  logic [AW-1:0] w_line0;
  logic [AW-1:0] w_line1;
  logic [7:0]    w_be;
  logic          w_go_resp;
  logic          w_we;
  logic [3:0]    w_rsp_rt;
  logic [63:0]   w_rsp_d0;
  logic [63:0]   w_rsp_d1;
  logic          w_unused_addr;

  assign w_unused_addr = ^r_addr[31:3+AW];

  always_comb begin
    w_bytes      = 4'd0;
    w_align_mask = 3'd0;
    w_size_ok    = 1'b1;
    case (r_size)
      3'b001:  begin w_bytes = 4'd1; w_align_mask = 3'd0; end
      3'b010:  begin w_bytes = 4'd2; w_align_mask = 3'd1; end
      3'b011:  begin w_bytes = 4'd4; w_align_mask = 3'd3; end
      3'b100:  begin w_bytes = 4'd8; w_align_mask = 3'd7; end
      default: w_size_ok = 1'b0;
    endcase
  end

  assign w_rq_ok = (r_rqtype == RQ_LOAD) || (r_rqtype == RQ_IMISS) || (r_rqtype == RQ_STORE);
  assign w_bad   = !w_size_ok || !w_rq_ok || ((r_addr[2:0] & w_align_mask) != 3'd0);
  assign w_idx   = r_addr[3 +: AW];
  assign w_line0 = {w_idx[AW-1:1], 1'b0};
  assign w_line1 = {w_idx[AW-1:1], 1'b1};

  always_comb begin
    w_be = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      if (b >= 32'(r_addr[2:0]) && b < 32'(r_addr[2:0]) + 32'(w_bytes))
        w_be[b] = 1'b1;
    end
  end

  // The response is captured on the same edge that leaves ACK (zero latency) or WAIT.
  assign w_go_resp = ((r_state == S_ACK) && (LATENCY == 0)) ||
                     ((r_state == S_WAIT) && (r_cnt <= 8'd1));
  assign w_we      = nrst && w_go_resp && (r_rqtype == RQ_STORE) && !w_bad;

  always_comb begin
    w_rsp_rt = '0;
    w_rsp_d0 = '0;
    w_rsp_d1 = '0;
    if (w_bad) begin
      w_rsp_rt = RT_ERR;
    end else if (r_rqtype == RQ_STORE) begin
      w_rsp_rt = RT_STACK;
    end else begin
      w_rsp_rt = (r_rqtype == RQ_IMISS) ? RT_IFILL : RT_LOAD;
      w_rsp_d0 = r_mem[w_line0];
      w_rsp_d1 = r_mem[w_line1];
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state  <= S_IDLE;
      r_rqtype <= '0;
      r_size   <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_cnt    <= '0;
      r_ack    <= 1'b0;
      r_val    <= 1'b0;
      r_d0     <= '0;
      r_d1     <= '0;
      r_rt     <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.transducer_l15_val) begin
            r_rqtype <= bus.transducer_l15_rqtype;
            r_size   <= bus.transducer_l15_size;
            r_addr   <= bus.transducer_l15_address;
            r_wdata  <= bus.transducer_l15_data;
            r_ack    <= 1'b1;
            r_state  <= S_ACK;
          end
`ifdef L15_RESP_INT_EN
          else if (int_req) begin
            r_val   <= 1'b1;
            r_rt    <= RT_INT;
            r_d0    <= 64'h1;
            r_d1    <= '0;
            r_state <= S_RESP;
          end
`endif
        end
        S_ACK: begin
          r_ack   <= 1'b0;
          r_cnt   <= 8'(LATENCY);
          r_state <= S_WAIT;
          if (!bus.transducer_l15_val || w_bad) r_err <= 1'b1;
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 8'd1;
        end
        S_RESP: begin
          if (bus.transducer_l15_req_ack) begin
            r_val   <= 1'b0;
            r_rt    <= '0;
            r_d0    <= '0;
            r_d1    <= '0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Overrides the ACK/WAIT next-state choice made above.
      if (w_go_resp) begin
        r_val   <= 1'b1;
        r_rt    <= w_rsp_rt;
        r_d0    <= w_rsp_d0;
        r_d1    <= w_rsp_d1;
        r_state <= S_RESP;
      end
    end
  end

  assign bus.l15_transducer_ack        = r_ack;
  assign bus.l15_transducer_header_ack = r_ack;
  assign bus.l15_transducer_val        = r_val;
  assign bus.l15_transducer_data_0     = r_d0;
  assign bus.l15_transducer_data_1     = r_d1;
  assign bus.l15_transducer_returntype = {28'd0, r_rt};
  assign bus.err                       = r_err;
endmodule

// File: tb/tb_l15_responder_model.sv
// Directed + randomized bench for l15_responder_model against a byte-level memory model.
module tb_l15_responder_model;
  localparam int unsigned DW  = 64;
  localparam int unsigned LAT = 2;
  localparam logic [4:0] LOAD  = 5'b00000;
  localparam logic [4:0] IMISS = 5'b10000;
  localparam logic [4:0] STORE = 5'b00001;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic int_req = 1'b0;
  l15_responder_model_if bus();

  l15_responder_model #(.MEM_DWORDS(DW), .LATENCY(LAT)) dut (
    .clk     (clk),
    .nrst    (nrst),
`ifdef L15_RESP_INT_EN
    .int_req (int_req),
`endif
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  logic [63:0] m [DW];
  bit          m_err = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: byte-addressed memory, 16-byte line reads, little-endian store lanes.
  task automatic model(input logic [4:0] rq, input logic [2:0] sz, input logic [31:0] a,
                       input logic [63:0] d, output logic [3:0] rt,
                       output logic [63:0] d0, output logic [63:0] d1);
    int unsigned nb, off, idx;
    logic [63:0] tmp;
    case (sz)
      3'd1: nb = 1;
      3'd2: nb = 2;
      3'd3: nb = 4;
      3'd4: nb = 8;
      default: nb = 0;
    endcase
    off = a % 8;
    idx = (a / 8) % DW;
    rt = 4'h0; d0 = '0; d1 = '0;
    if (nb == 0 || !(rq == LOAD || rq == IMISS || rq == STORE) || (off % nb) != 0) begin
      rt = 4'hF;
      m_err = 1'b1;
    end else if (rq == STORE) begin
      tmp = m[idx];
      for (int unsigned k = 0; k < nb; k++) tmp[8*(off+k) +: 8] = d[8*(off+k) +: 8];
      m[idx] = tmp;
      rt = 4'h4;
    end else begin
      d0 = m[idx - (idx % 2)];
      d1 = m[idx - (idx % 2) + 1];
      rt = (rq == IMISS) ? 4'h1 : 4'h0;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"},  64'(bus.l15_transducer_ack), 64'd0);
    chk({tag, "_hack"}, 64'(bus.l15_transducer_header_ack), 64'd0);
    chk({tag, "_val"},  64'(bus.l15_transducer_val), 64'd0);
    chk({tag, "_d0"},   bus.l15_transducer_data_0, 64'd0);
    chk({tag, "_d1"},   bus.l15_transducer_data_1, 64'd0);
    chk({tag, "_rt"},   64'(bus.l15_transducer_returntype), 64'd0);
    chk({tag, "_err"},  64'(bus.err), 64'd0);
  endtask

  task automatic txn(input logic [4:0] rq, input logic [2:0] sz, input logic [31:0] a,
                     input logic [63:0] d, input int unsigned hold, input bit drop_val);
    logic [3:0]  ert;
    logic [63:0] e0, e1;
    @(negedge clk);
    bus.transducer_l15_rqtype  = rq;
    bus.transducer_l15_size    = sz;
    bus.transducer_l15_address = a;
    bus.transducer_l15_data    = d;
    bus.transducer_l15_val     = 1'b1;
    @(posedge clk); #1;
    chk("ack", 64'(bus.l15_transducer_ack), 64'd1);
    chk("header_ack", 64'(bus.l15_transducer_header_ack), 64'd1);
    if (drop_val) begin
      bus.transducer_l15_val = 1'b0;
      m_err = 1'b1;
    end
    model(rq, sz, a, d, ert, e0, e1);
    @(posedge clk); #1;
    bus.transducer_l15_val = 1'b0;
    chk("ack_pulse", 64'(bus.l15_transducer_ack), 64'd0);
    chk("val_early", 64'(bus.l15_transducer_val), 64'd0);
    repeat (LAT - 1) begin
      @(posedge clk); #1;
      chk("val_early", 64'(bus.l15_transducer_val), 64'd0);
    end
    @(posedge clk); #1;
    chk("val", 64'(bus.l15_transducer_val), 64'd1);
    chk("returntype", 64'(bus.l15_transducer_returntype), 64'(ert));
    chk("data_0", bus.l15_transducer_data_0, e0);
    chk("data_1", bus.l15_transducer_data_1, e1);
    chk("err", 64'(bus.err), 64'(m_err));
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_val", 64'(bus.l15_transducer_val), 64'd1);
      chk("hold_rt", 64'(bus.l15_transducer_returntype), 64'(ert));
      chk("hold_d0", bus.l15_transducer_data_0, e0);
      chk("hold_d1", bus.l15_transducer_data_1, e1);
    end
    bus.transducer_l15_req_ack = 1'b1;
    @(posedge clk); #1;
    bus.transducer_l15_req_ack = 1'b0;
    chk("val_drop", 64'(bus.l15_transducer_val), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    m_err = 1'b0;
    chk_all_zero("rst");
  endtask

  // Store aborted by reset after 'edges' clock edges past acceptance; it must not land.
  task automatic rst_mid_store(input logic [31:0] a, input logic [63:0] d, input int unsigned edges);
    @(negedge clk);
    bus.transducer_l15_rqtype  = STORE;
    bus.transducer_l15_size    = 3'd4;
    bus.transducer_l15_address = a;
    bus.transducer_l15_data    = d;
    bus.transducer_l15_val     = 1'b1;
    @(posedge clk); #1;
    repeat (edges - 1) begin
      @(posedge clk); #1;
      bus.transducer_l15_val = 1'b0;
    end
    bus.transducer_l15_val = 1'b0;
    nrst = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    m_err = 1'b0;
    chk_all_zero("rst_mid");
  endtask

  initial begin
    logic [63:0] rd;
    logic [4:0]  rq;
    logic [2:0]  sz;
    logic [31:0] a;
    bus.transducer_l15_rqtype  = '0;
    bus.transducer_l15_size    = '0;
    bus.transducer_l15_address = '0;
    bus.transducer_l15_data    = '0;
    bus.transducer_l15_val     = 1'b0;
    bus.transducer_l15_req_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    nrst = 1'b1;

    for (int unsigned i = 0; i < DW; i++) txn(STORE, 3'd4, 32'(i * 8), {$urandom, $urandom}, 0, 1'b0);

    txn(STORE, 3'd4, 32'h40, 64'h1122334455667788, 0, 1'b0);
    txn(LOAD,  3'd4, 32'h40, 64'h0, 0, 1'b0);
    txn(STORE, 3'd4, 32'h40, 64'h0, 0, 1'b0);
    txn(STORE, 3'd1, 32'h43, 64'h00000000AB000000, 0, 1'b0);
    txn(LOAD,  3'd4, 32'h40, 64'h0, 0, 1'b0);
    txn(STORE, 3'd4, 32'h10, 64'hAAAA_0000_1234_5678, 0, 1'b0);
    txn(STORE, 3'd4, 32'h18, 64'hBBBB_1111_9ABC_DEF0, 0, 1'b0);
    txn(IMISS, 3'd4, 32'h18, 64'h0, 0, 1'b0);
    txn(LOAD,  3'd3, 32'h14, 64'h0, 5, 1'b0);

    txn(LOAD,  3'd3, 32'h2, 64'h0, 0, 1'b0);
    do_reset();
    txn(LOAD,  3'd4, 32'h0, 64'h0, 0, 1'b0);
    txn(LOAD,  3'd4, 32'h8, 64'h0, 0, 1'b1);
    do_reset();
    txn(STORE, 3'd2, 32'h41, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0);
    txn(STORE, 3'd0, 32'h40, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0);
    txn(5'b00010, 3'd4, 32'h40, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0);
    txn(LOAD,  3'd4, 32'h40, 64'h0, 0, 1'b0);
    do_reset();

    rst_mid_store(32'h20, 64'hDEAD_BEEF_DEAD_BEEF, 1);
    rst_mid_store(32'h28, 64'hCAFE_F00D_CAFE_F00D, LAT + 1);
    txn(LOAD,  3'd4, 32'h20, 64'h0, 0, 1'b0);
    txn(STORE, 3'd4, 32'h1000_0048, 64'h0123_4567_89AB_CDEF, 0, 1'b0);
    txn(LOAD,  3'd4, 32'h48, 64'h0, 0, 1'b0);

    for (int unsigned i = 0; i < 150; i++) begin
      case ($urandom_range(2, 0))
        0: rq = LOAD;
        1: rq = IMISS;
        default: rq = STORE;
      endcase
      if ($urandom_range(19, 0) == 0) rq = 5'($urandom);
      sz = 3'($urandom_range(4, 1));
      if ($urandom_range(19, 0) == 0) sz = 3'($urandom);
      a = ($urandom & 32'hFFFF_FE00) | 32'($urandom_range(DW - 1, 0) * 8);
      if ($urandom_range(7, 0) == 0) a[2:0] = 3'($urandom);
      else if (sz >= 3'd1 && sz <= 3'd4) begin
        rd = 64'($urandom_range(7, 0));
        a[2:0] = 3'(rd[2:0] & ~((3'd1 << (sz - 3'd1)) - 3'd1));
      end
      txn(rq, sz, a, {$urandom, $urandom}, $urandom_range(3, 0), 1'b0);
      if ($urandom_range(15, 0) == 0) do_reset();
    end

`ifdef L15_RESP_INT_EN
    @(negedge clk);
    int_req = 1'b1;
    @(posedge clk); #1;
    chk("int_val", 64'(bus.l15_transducer_val), 64'd1);
    chk("int_ack", 64'(bus.l15_transducer_ack), 64'd0);
    chk("int_rt", 64'(bus.l15_transducer_returntype), 64'd7);
    chk("int_d0", bus.l15_transducer_data_0, 64'd1);
    chk("int_d1", bus.l15_transducer_data_1, 64'd0);
    bus.transducer_l15_req_ack = 1'b1;
    @(posedge clk); #1;
    bus.transducer_l15_req_ack = 1'b0;
    chk("int_drop", 64'(bus.l15_transducer_val), 64'd0);
    txn(LOAD, 3'd4, 32'h40, 64'h0, 0, 1'b0);
    @(posedge clk); #1;
    int_req = 1'b0;
    chk("int_pend_val", 64'(bus.l15_transducer_val), 64'd1);
    chk("int_pend_rt", 64'(bus.l15_transducer_returntype), 64'd7);
    bus.transducer_l15_req_ack = 1'b1;
    @(posedge clk); #1;
    bus.transducer_l15_req_ack = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/l15_responder_model.md
# l15_responder_model

Synthesizable single-outstanding responder for the core's OpenPiton transducer-to-L1.5 interface. It takes the L1.5 side of that interface: it accepts load, instruction-fill and store requests from the core's transducer, services them against an internal 64-bit-wide memory after a programmable latency, and returns responses. It replaces the real L1.5 in standalone core simulation and UVM benches.

## Interface
Parameters:
- MEM_DWORDS, 4096: memory depth in 64-bit doublewords; must be a power of 2 and ≥ 2.
- LATENCY, 2: cycles spent in WAIT, range 0..255.

Ports:
- clk  input  1  clock
- nrst  input  1  reset; synchronous, active-low
- transducer_l15_rqtype  input  5  request type: 5'b00000 LOAD, 5'b10000 IMISS, 5'b00001 STORE
- transducer_l15_size  input  3  access size: 3'b001 1B, 3'b010 2B, 3'b011 4B, 3'b100 8B
- transducer_l15_address  input  32  byte address
- transducer_l15_data  input  64  store data
- transducer_l15_val  input  1  request valid
- l15_transducer_ack  output  1  request accepted
- l15_transducer_header_ack  output  1  header accepted
- l15_transducer_val  output  1  response valid
- l15_transducer_data_0  output  64  response doubleword 0
- l15_transducer_data_1  output  64  response doubleword 1
- l15_transducer_returntype  output  32  response type in bits [3:0]; bits [31:4] are always 0
- transducer_l15_req_ack  input  1  response consumed
- err  output  1  sticky protocol or decode error flag
- int_req  input  1  interrupt injection request; present only with L15_RESP_INT_EN

## Operation
- Reset value of every output is 0; the FSM enters IDLE; memory contents are not affected by reset.
- FSM states: IDLE, ACK, WAIT, RESP.
- IDLE: when transducer_l15_val=1, latch rqtype, size, address and data, then go to ACK.
- ACK: drive l15_transducer_ack=1 and l15_transducer_header_ack=1 for exactly one cycle. Load the latency counter with LATENCY. Go to WAIT, or straight to RESP if LATENCY=0.
- WAIT: decrement the counter each cycle. When the counter reaches 1, go to RESP.
  - A STORE performs its memory write on the WAIT→RESP (or ACK→RESP) transition.
- RESP: hold l15_transducer_val=1 with stable data and returntype until transducer_l15_req_ack=1 is sampled, then go to IDLE.
- Memory index: dword index = address[3+log2(MEM_DWORDS)-1:3]. Upper address bits are ignored, so accesses alias and wrap.
- LOAD and IMISS return the 16-byte-aligned line:
  - data_0 = mem[{idx[n-1:1],1'b0}], data_1 = mem[{idx[n-1:1],1'b1}].
  - returntype is 4'b0000 for LOAD and 4'b0001 for IMISS (IFILL).
- STORE byte lanes are little-endian. Write lanes address[2:0] .. address[2:0]+bytes-1 of mem[idx], with data taken from the same lanes of transducer_l15_data.
  - Response returntype is 4'b0100 (ST_ACK); data_0 and data_1 are 0.
- Misaligned access (address not a multiple of the size) or an unknown size or rqtype:
  - request is still acked;
  - no memory write occurs;
  - response returntype is 4'b1111 with data 0;
  - err is set. err clears only on reset.
- transducer_l15_val=0 while in ACK is a protocol violation: set err and continue the transaction normally.
- transducer_l15_req_ack while not in RESP is ignored.

## Timing
- Request accept: val sampled high in IDLE at cycle T → ack and header_ack high at T+1, for one cycle only.
- Response: l15_transducer_val rises at T+2+LATENCY.
- Load-after-store: a load accepted after a store's response sees the stored data.
- Back-to-back: req_ack sampled at cycle R → IDLE at R+1, so the earliest next accept is at R+1 and the next ack at R+2.
- Reset mid-transaction: all outputs are 0 on the following cycle; a store not yet written is dropped.

## Configuration
- L15_RESP_INT_EN defined:
  - int_req port exists.
  - In IDLE with transducer_l15_val=0 and int_req=1, go directly to RESP with returntype 4'b0111 (INT_RET), data_0 = 64'h1 and data_1 = 0; no ack is issued.
  - When int_req and transducer_l15_val are both high in IDLE, the request wins and the interrupt stays pending, since it is level-sensitive.
- Not defined: int_req is absent and return type 4'b0111 is never produced.

## Test plan
- STORE size 3'b100, address 0x40, data 64'h1122334455667788, LATENCY=2 → ack at T+1, val at T+4 with returntype 4; a following LOAD at 0x40 → data_0=64'h1122334455667788.
- STORE 1B to address 0x43 with data 64'h00000000AB000000 over a zeroed memory → LOAD 0x40 returns data_0=64'h00000000AB000000.
- IMISS at address 0x18 after dwords 2 and 3 are written with A and B → data_0=A, data_1=B, returntype 1.
- Response held: req_ack low for 5 cycles → val, data and returntype stay constant; req_ack high → val low on the next cycle.
- 4B LOAD at address 0x2 → returntype 4'hF, err=1, no memory change; nrst low for one cycle → err=0 and all outputs 0.
- With L15_RESP_INT_EN defined and int_req=1 in IDLE → val at the next cycle, returntype 7, data_0=1, no ack.
